// File: rtl/decode_scan_n.sv
// decode_scan_n: registered N-to-2^N one-hot decoder with a built-in dwell-timed scan mode
module decode_scan_n #(
   parameter int N          = 2,
   parameter int DIV        = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       x,
   input  logic [N-1:0]       limit,
   output logic [(1<<N)-1:0]  y,
   output logic [N-1:0]       idx,
   output logic               wrap
);
   localparam int W  = 1 << N;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(DIV - 1);
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
   state_t         state_q, state_d;
   logic [DW-1:0]  dwell_q, dwell_d;
   logic [N-1:0]   idx_q, idx_d;
   logic           wrap_q, wrap_d;
   logic [W-1:0]   y_q, y_d;
   logic           adv;
   logic           at_end;
   // next state follows the sampled en/mode pair; scan only advances once the dwell has expired
   always_comb begin
      state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
      adv     = (state_q == SCAN) && (dwell_q == LAST);
      at_end  = idx_q >= limit;
      dwell_d = '0;
      idx_d   = '0;
      wrap_d  = 1'b0;
      if (state_d == DIRECT) idx_d = x;
      else if (state_d == SCAN && state_q == SCAN) begin
         dwell_d = adv ? '0 : dwell_q + 1'b1;
         idx_d   = !adv ? idx_q : (at_end ? '0 : idx_q + 1'b1);
         wrap_d  = adv && at_end;
      end
      y_d = ((state_d == IDLE) ? '0 : (W'(1) << idx_d)) ^ {W{ACTIVE_LOW}};
   end
   // state and output registers; reset dominates every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dwell_q <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         y_q     <= {W{ACTIVE_LOW}};
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         y_q     <= y_d;
      end
   end
   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_decode_scan_n.sv
// tb_decode_scan_n: table vectors, directed scan sequences and a randomized run against a behavioural model
module tb_decode_scan_n;
   logic clk = 1'b0;
   logic rst, en, mode;
   logic [1:0] x, limit;
   logic [3:0] y_a, y_b;
   logic [1:0] idx_a, idx_b;
   logic wrap_a, wrap_b;
   int vectors = 0;
   int miscompares = 0;
   always #5 clk = ~clk;
   decode_scan_n #(.N(2), .DIV(3), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .limit(limit),
      .y(y_a), .idx(idx_a), .wrap(wrap_a));
   decode_scan_n #(.N(2), .DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .limit(limit),
      .y(y_b), .idx(idx_b), .wrap(wrap_b));
   // behavioural model: per DUT, whether a scan is running, the position, cycles spent there, wrap flag
   int m_div[2] = '{3, 1};
   int m_al[2]  = '{0, 1};
   int m_scan[2], m_pos[2], m_cnt[2], m_wrap[2], m_act[2];
   task automatic mdl_edge(input int j, input logic r, e, m, input logic [1:0] xx, ll);
      if (r || !e) begin
         m_scan[j] = 0; m_pos[j] = 0; m_cnt[j] = 0; m_wrap[j] = 0; m_act[j] = 0;
      end else if (!m) begin
         m_scan[j] = 0; m_pos[j] = int'(xx); m_cnt[j] = 0; m_wrap[j] = 0; m_act[j] = 1;
      end else if (m_scan[j] == 0) begin
         m_scan[j] = 1; m_pos[j] = 0; m_cnt[j] = 0; m_wrap[j] = 0; m_act[j] = 1;
      end else begin
         m_wrap[j] = 0;
         m_cnt[j]++;
         if (m_cnt[j] == m_div[j]) begin
            m_cnt[j] = 0;
            if (m_pos[j] >= int'(ll)) begin
               m_pos[j] = 0;
               m_wrap[j] = 1;
            end else m_pos[j]++;
         end
      end
   endtask
   function automatic int exp_y(input int j);
      int v;
      v = m_act[j] != 0 ? (1 << m_pos[j]) : 0;
      return m_al[j] != 0 ? (v ^ 15) : v;
   endfunction
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic step(input logic r, e, m, input logic [1:0] xx, ll);
      rst = r; en = e; mode = m; x = xx; limit = ll;
      @(posedge clk);
      mdl_edge(0, r, e, m, xx, ll);
      mdl_edge(1, r, e, m, xx, ll);
      #1;
   endtask
   task automatic model_check();
      cmp("rand_y_a", 32'(y_a), 32'(exp_y(0)));
      cmp("rand_idx_a", 32'(idx_a), 32'(m_pos[0]));
      cmp("rand_wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
      cmp("rand_y_b", 32'(y_b), 32'(exp_y(1)));
      cmp("rand_idx_b", 32'(idx_b), 32'(m_pos[1]));
      cmp("rand_wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
   endtask
   typedef struct {
      logic r, e, m;
      logic [1:0] x, l;
      logic [3:0] y;
      logic [1:0] i;
      logic w;
   } vec_t;
   function automatic vec_t v(input logic r, e, m, input logic [1:0] xx, l, input logic [3:0] yy,
                              input logic [1:0] i, input logic w);
      vec_t t;
      t.r = r; t.e = e; t.m = m; t.x = xx; t.l = l; t.y = yy; t.i = i; t.w = w;
      return t;
   endfunction
   vec_t tbl[14];
   initial begin
      for (int j = 0; j < 2; j++) begin
         m_scan[j] = 0; m_pos[j] = 0; m_cnt[j] = 0; m_wrap[j] = 0; m_act[j] = 0;
      end
      rst = 1'b1; en = 1'b0; mode = 1'b0; x = 2'd0; limit = 2'd0;
      tbl[0]  = v(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 4'b0000, 2'd0, 1'b0);
      tbl[1]  = v(1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 4'b0000, 2'd0, 1'b0);
      tbl[2]  = v(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0001, 2'd0, 1'b0);
      tbl[3]  = v(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 4'b0010, 2'd1, 1'b0);
      tbl[4]  = v(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 4'b0100, 2'd2, 1'b0);
      tbl[5]  = v(1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 4'b1000, 2'd3, 1'b0);
      tbl[6]  = v(1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 4'b0000, 2'd0, 1'b0);
      tbl[7]  = v(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 4'b0001, 2'd0, 1'b0);
      tbl[8]  = v(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 4'b0001, 2'd0, 1'b0);
      tbl[9]  = v(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 4'b0001, 2'd0, 1'b0);
      tbl[10] = v(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 4'b0010, 2'd1, 1'b0);
      tbl[11] = v(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 4'b0010, 2'd1, 1'b0);
      tbl[12] = v(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 4'b0010, 2'd1, 1'b0);
      tbl[13] = v(1'b0, 1'b1, 1'b1, 2'd3, 2'd0, 4'b0001, 2'd0, 1'b1);
      // table: reset, direct decode, enable drop, scan entry, limit lowered below idx
      for (int k = 0; k < 14; k++) begin
         step(tbl[k].r, tbl[k].e, tbl[k].m, tbl[k].x, tbl[k].l);
         cmp($sformatf("tbl%0d_y", k), 32'(y_a), 32'(tbl[k].y));
         cmp($sformatf("tbl%0d_idx", k), 32'(idx_a), 32'(tbl[k].i));
         cmp($sformatf("tbl%0d_wrap", k), 32'(wrap_a), 32'(tbl[k].w));
      end
      // full scan with limit 3: 12-cycle period, wrap on first idx=0 after 3
      step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      for (int k = 0; k < 24; k++) begin
         step(1'b0, 1'b1, 1'b1, 2'd1, 2'd3);
         cmp("scan_idx", 32'(idx_a), 32'((k / 3) % 4));
         cmp("scan_y", 32'(y_a), 32'(1 << ((k / 3) % 4)));
         cmp("scan_wrap", 32'(wrap_a), 32'(k > 0 && k % 12 == 0));
      end
      // limit dropped to 1 while idx=3: next advance wraps, then 6-cycle period
      step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      for (int k = 0; k < 24; k++) begin
         step(1'b0, 1'b1, 1'b1, 2'd0, k < 10 ? 2'd3 : 2'd1);
         if (k == 9) cmp("lim_at3", 32'(idx_a), 32'd3);
         if (k >= 12) begin
            cmp("lim_idx", 32'(idx_a), 32'(((k - 12) / 3) % 2));
            cmp("lim_wrap", 32'(wrap_a), 32'((k - 12) % 6 == 0));
         end
      end
      // DIV=1 active-low with limit 2: advances every cycle
      step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      cmp("div1_rst_y", 32'(y_b), 32'hF);
      for (int k = 0; k < 9; k++) begin
         step(1'b0, 1'b1, 1'b1, 2'd3, 2'd2);
         cmp("div1_y", 32'(y_b), 32'(15 & ~(1 << (k % 3))));
         cmp("div1_wrap", 32'(wrap_b), 32'(k > 0 && k % 3 == 0));
      end
      // mode switch mid-scan, restart with full dwell, then reset mid-scan
      step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3);
      cmp("ms_at2", 32'(idx_a), 32'd2);
      step(1'b0, 1'b1, 1'b0, 2'd3, 2'd3);
      cmp("ms_direct_y", 32'(y_a), 32'h8);
      cmp("ms_direct_idx", 32'(idx_a), 32'd3);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3);
         cmp("ms_rescan_idx", 32'(idx_a), k < 3 ? 32'd0 : 32'd1);
         cmp("ms_rescan_wrap", 32'(wrap_a), 32'd0);
      end
      step(1'b1, 1'b1, 1'b1, 2'd0, 2'd3);
      cmp("ms_rst_y", 32'(y_a), 32'h0);
      cmp("ms_rst_idx", 32'(idx_a), 32'd0);
      cmp("ms_rst_wrap", 32'(wrap_a), 32'd0);
      step(1'b0, 1'b1, 1'b1, 2'd0, 2'd3);
      cmp("ms_reentry_y", 32'(y_a), 32'h1);
      cmp("ms_reentry_wrap", 32'(wrap_a), 32'd0);
      // randomized run against the model for both parameterisations
      begin
         logic [1:0] lim_r;
         lim_r = 2'($urandom_range(0, 3));
         for (int k = 0; k < 600; k++) begin
            if ($urandom % 16 == 0) lim_r = 2'($urandom_range(0, 3));
            step($urandom % 40 == 0, $urandom % 8 != 0, $urandom % 4 != 0, 2'($urandom), lim_r);
            model_check();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
